// File: rtl/r52_pkg.sv
// Shared definitions for the R52 program loader: width defaults, loader states
// and the R52 instruction field positions.
package r52_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  // Opcode bits are one-hot in the upper byte; the operand address is the low nibble.
  localparam int OPC_BRP_BIT   = 4;
  localparam int OPC_BRA_BIT   = 6;
  localparam int OPC_SUB_BIT   = 8;
  localparam int OPC_OUT_BIT   = 9;
  localparam int OPC_LOAD_BIT  = 10;
  localparam int OPC_STORE_BIT = 11;
  localparam int OPERAND_MSB   = 3;
  localparam int OPERAND_LSB   = 0;

endpackage

// File: rtl/r52_prog_loader_if.sv
// Serial-load and RAM1-write signal bundle between the program source and the loader.
interface r52_prog_loader_if
  import r52_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  start;
  logic [ADDR_WIDTH-1:0] prog_len;
  logic                  ser_bit;
  logic                  ser_valid;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_we;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  overrun;

  modport master (
    output start, prog_len, ser_bit, ser_valid,
    input  ram_addr, ram_data, ram_we, cpu_hold, busy, done, overrun
  );

  modport slave (
    input  start, prog_len, ser_bit, ser_valid,
    output ram_addr, ram_data, ram_we, cpu_hold, busy, done, overrun
  );

endinterface

// File: rtl/r52_ser_deser.sv
// Serial-to-parallel word assembler: MSB-first shift register plus bit counter.
// word/word_done present the completed word in the same cycle its last bit arrives.
module r52_ser_deser
  import r52_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic                  ser_bit,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Only the older DATA_WIDTH-1 bits need storage; the newest bit comes straight from ser_bit.
  logic [DATA_WIDTH-2:0] shreg_r;
  logic [CNT_W-1:0]      cnt_r;

  // Next word value and end-of-word detect.
  always_comb begin
    word      = {shreg_r, ser_bit};
    word_done = 1'b0;
    if (shift_en && (cnt_r == LAST_BIT)) begin
      word_done = 1'b1;
    end else begin
      word_done = 1'b0;
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r <= '0;
      cnt_r   <= '0;
    end else if (clear) begin
      shreg_r <= '0;
      cnt_r   <= '0;
    end else if (shift_en) begin
      shreg_r <= word[DATA_WIDTH-2:0];
      cnt_r   <= word_done ? '0 : cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/r52_prog_loader.sv
// R52 program loader: assembles serial words, writes them to RAM1 at sequential
// addresses and holds the CPU in reset until a full program has been loaded.
module r52_prog_loader
  import r52_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic               timer555,
  input logic               reset_count,
  r52_prog_loader_if.slave  bus
);

  loader_state_e         state_r;
  logic [ADDR_WIDTH-1:0] len_r;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0] ram_data_r;
  logic                  ram_we_r;
  logic                  cpu_hold_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  overrun_r;

  logic                  shift_en_s;
  logic                  clear_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  word_done_s;
  logic [ADDR_WIDTH-1:0] last_addr_s;

  // Deserialiser control and final-address compare (length 0 wraps to the top address).
  always_comb begin
    shift_en_s  = (state_r == ST_SHIFT) && bus.ser_valid;
    clear_s     = (state_r != ST_SHIFT);
    last_addr_s = len_r - ADDR_WIDTH'(1);
  end

  r52_ser_deser #(.DATA_WIDTH(DATA_WIDTH)) u_ser_deser (
    .clk       (timer555),
    .rst       (reset_count),
    .clear     (clear_s),
    .shift_en  (shift_en_s),
    .ser_bit   (bus.ser_bit),
    .word      (word_s),
    .word_done (word_done_s)
  );

  // Loader FSM with registered outputs.
  always_ff @(posedge timer555 or posedge reset_count) begin
    if (reset_count) begin
      state_r    <= ST_IDLE;
      len_r      <= '0;
      ram_addr_r <= '0;
      ram_data_r <= '0;
      ram_we_r   <= 1'b0;
      cpu_hold_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      ram_we_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_r    <= ST_SHIFT;
            len_r      <= bus.prog_len;
            ram_addr_r <= '0;
            overrun_r  <= 1'b0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            cpu_hold_r <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (word_done_s) begin
            ram_data_r <= word_s;
            ram_we_r   <= 1'b1;
            state_r    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // A bit arriving while the write is in progress has nowhere to go.
          if (bus.ser_valid) begin
            overrun_r <= 1'b1;
          end
          if (ram_addr_r == last_addr_s) begin
            state_r    <= ST_DONE;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            cpu_hold_r <= 1'b0;
          end else begin
            ram_addr_r <= ram_addr_r + ADDR_WIDTH'(1);
            state_r    <= ST_SHIFT;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          cpu_hold_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ram_addr = ram_addr_r;
  assign bus.ram_data = ram_data_r;
  assign bus.ram_we   = ram_we_r;
  assign bus.cpu_hold = cpu_hold_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_r52_prog_loader.sv
// Directed, table-driven bench for the R52 program loader.
module tb_r52_prog_loader;
  import r52_pkg::*;

  logic timer555;
  logic reset_count;
  int   total;
  int   bad;
  bit   prev_we;
  logic [15:0] wr_q[$];

  r52_prog_loader_if bus ();

  r52_prog_loader dut (
    .timer555    (timer555),
    .reset_count (reset_count),
    .bus         (bus)
  );

  initial timer555 = 1'b0;
  always #5 timer555 = ~timer555;

  typedef struct {
    logic [11:0] word;
    logic [11:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Record every RAM write and flag back-to-back strobes.
  always @(negedge timer555) begin
    if (bus.ram_we === 1'b1) begin
      wr_q.push_back({bus.ram_addr, bus.ram_data});
      total++;
      if (prev_we) begin
        bad++;
        $display("FAIL we_twice: got 1 expected 0 at %0t", $time);
      end
    end
    prev_we = (bus.ram_we === 1'b1);
  end

  task automatic cyc();
    @(posedge timer555);
    #1;
  endtask

  task automatic do_start(input logic [3:0] len);
    bus.start = 1'b1;
    bus.prog_len = len;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.ser_valid = 1'b1;
    bus.ser_bit = b;
    cyc();
    bus.ser_valid = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] w, input int gap, input bit chk_busy);
    for (int i = 11; i >= 0; i--) begin
      send_bit(w[i]);
      if (chk_busy) chk("busy", bus.busy, 1);
      repeat (gap) cyc();
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    chk("done_timeout", bus.done, 1);
  endtask

  task automatic chk_wr(input int idx, input logic [3:0] a, input logic [11:0] d);
    if (idx < wr_q.size()) begin
      chk("wr_addr", wr_q[idx][15:12], a);
      chk("wr_data", wr_q[idx][11:0], d);
    end else begin
      chk("wr_missing", wr_q.size(), idx + 1);
    end
  endtask

  logic [24:0] stream;

  initial begin
    total = 0;
    bad = 0;
    prev_we = 1'b0;
    bus.start = 1'b0;
    bus.prog_len = 4'd0;
    bus.ser_bit = 1'b0;
    bus.ser_valid = 1'b0;

    vecs[0] = '{12'b0100_0000_0000, 12'h400};
    vecs[1] = '{12'b1000_0000_0001, 12'h801};
    vecs[2] = '{12'b1111_1111_1111, 12'hFFF};
    vecs[3] = '{12'b0000_0000_0000, 12'h000};
    vecs[4] = '{12'b1010_0101_1100, 12'hA5C};
    vecs[5] = '{12'b0000_0000_0110, 12'h006};

    reset_count = 1'b1;
    cyc();
    cyc();
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_data", bus.ram_data, 0);
    chk("rst_we", bus.ram_we, 0);
    chk("rst_hold", bus.cpu_hold, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovr", bus.overrun, 0);
    reset_count = 1'b0;
    cyc();
    // IDLE ignores serial traffic.
    send_bit(1'b1);
    chk("idle_busy", bus.busy, 0);
    chk("idle_hold", bus.cpu_hold, 1);

    // Single-word loads; from the second entry on, each restarts from DONE.
    for (int v = 0; v < 6; v++) begin
      wr_q.delete();
      do_start(4'd1);
      chk("st_hold", bus.cpu_hold, 1);
      chk("st_busy", bus.busy, 1);
      chk("st_done", bus.done, 0);
      send_word(vecs[v].word, 0, 1'b0);
      chk("v_we", bus.ram_we, 1);
      chk("v_addr", bus.ram_addr, 0);
      chk("v_data", bus.ram_data, vecs[v].exp_data);
      cyc();
      chk("v_done", bus.done, 1);
      chk("v_hold", bus.cpu_hold, 0);
      chk("v_we_off", bus.ram_we, 0);
      send_bit(1'b1);
      chk("v_nwr", wr_q.size(), 1);
      chk_wr(0, 4'd0, vecs[v].exp_data);
    end

    // Two words with ser_valid at one cycle in three.
    wr_q.delete();
    do_start(4'd2);
    send_word(12'(1 << OPC_LOAD_BIT), 2, 1'b1);
    send_word(12'((1 << OPC_STORE_BIT) | 1), 2, 1'b1);
    wait_done(10);
    chk("gap_nwr", wr_q.size(), 2);
    chk_wr(0, 4'd0, 12'h400);
    chk_wr(1, 4'd1, 12'h801);

    // Full sixteen-word program, prog_len=0.
    wr_q.delete();
    do_start(4'd0);
    for (int i = 0; i < 16; i++) begin
      send_word(12'(i), 0, 1'b0);
      chk("full_addr", bus.ram_addr, i);
      cyc();
    end
    chk("full_done", bus.done, 1);
    chk("full_last", bus.ram_addr, 15);
    repeat (3) cyc();
    chk("full_nwr", wr_q.size(), 16);
    for (int i = 0; i < 16; i++) chk_wr(i, 4'(i), 12'(i));

    // Continuous ser_valid: the 13th bit lands in WRITE and is dropped.
    wr_q.delete();
    stream = {12'h5A3, 1'b1, 12'h3C6};
    do_start(4'd2);
    for (int i = 24; i >= 0; i--) begin
      bus.ser_valid = 1'b1;
      bus.ser_bit = stream[i];
      cyc();
    end
    bus.ser_valid = 1'b0;
    chk("ovr_we", bus.ram_we, 1);
    cyc();
    chk("ovr_done", bus.done, 1);
    chk("ovr_flag", bus.overrun, 1);
    chk("ovr_nwr", wr_q.size(), 2);
    chk_wr(0, 4'd0, 12'h5A3);
    chk_wr(1, 4'd1, 12'h3C6);
    do_start(4'd1);
    chk("ovr_clr", bus.overrun, 0);
    send_word(12'h123, 0, 1'b0);
    cyc();
    chk("ovr_clr_done", bus.done, 1);
    chk("ovr_stay0", bus.overrun, 0);

    // Reset in the middle of a word.
    wr_q.delete();
    do_start(4'd2);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    reset_count = 1'b1;
    #1;
    chk("mid_data", bus.ram_data, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_hold", bus.cpu_hold, 1);
    chk("mid_done", bus.done, 0);
    cyc();
    reset_count = 1'b0;
    repeat (2) cyc();
    chk("mid_nwr", wr_q.size(), 0);
    chk("mid_hold2", bus.cpu_hold, 1);
    do_start(4'd1);
    send_word(12'h801, 0, 1'b0);
    chk("re_we", bus.ram_we, 1);
    cyc();
    chk("re_done", bus.done, 1);
    chk("re_nwr", wr_q.size(), 1);
    chk_wr(0, 4'd0, 12'h801);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
